// File: rtl/invader_formation_ctrl.sv
// ---------------------------------------------------------------------------
// invader_formation_ctrl
//
// Sequences the enemy formation: keeps the grid origin, march direction and
// alive mask. The grid marches sideways one STEP_X per step and steps down
// by STEP_Y at the screen edges. Steps happen every `period` video frames,
// and the period shrinks as enemies die.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high
//   frame_tick   1-cycle pulse per video frame
//   hit_valid    1-cycle pulse: a shot hit enemy (hit_col, hit_row)
//   hit_col      column index of the hit
//   hit_row      row index of the hit
//   new_wave     1-cycle pulse: restart formation (only in CLEARED/INVADED)
//   origin_x     x of column 0 left edge
//   origin_y     y of row 0 top edge
//   alive_mask   bit r*COLS+c = enemy (c,r) alive
//   alive_count  popcount of alive_mask
//   dir_right    1 = marching right
//   kill_pulse   1-cycle pulse when a hit clears a live enemy
//   cleared      level, formation wiped out
//   invaded      level, formation reached the invasion line
//   fsm_state    debug view of the formation state (0 RUN, 1 CLEARED,
//                2 INVADED)
//
// Handshake: hit_valid, frame_tick and new_wave are valid-only pulses with no
// ready; each is sampled on exactly the one clk edge where it is high and is
// never back-pressured. A pulse that is not applicable in the current state
// is dropped.
// ---------------------------------------------------------------------------
module invader_formation_ctrl #(
   parameter int COLS        = 8,
   parameter int ROWS        = 3,
   parameter int X0          = 40,
   parameter int Y0          = 40,
   parameter int DX          = 64,
   parameter int DY          = 40,
   parameter int SPRITE_W    = 32,
   parameter int SPRITE_H    = 24,
   parameter int STEP_X      = 4,
   parameter int STEP_Y      = 10,
   parameter int X_MIN       = 0,
   parameter int X_MAX       = 639,
   parameter int Y_LIMIT     = 440,
   parameter int BASE_FRAMES = 30,
   parameter int MIN_FRAMES  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_tick,
   input  logic                 hit_valid,
   input  logic [2:0]           hit_col,
   input  logic [1:0]           hit_row,
   input  logic                 new_wave,
   output logic [9:0]           origin_x,
   output logic [9:0]           origin_y,
   output logic [COLS*ROWS-1:0] alive_mask,
   output logic [5:0]           alive_count,
   output logic                 dir_right,
   output logic                 kill_pulse,
   output logic                 cleared,
   output logic                 invaded,
   output logic [1:0]           fsm_state
);

   localparam int N  = COLS * ROWS;
   localparam int FW = $clog2(BASE_FRAMES + 1);

   // 11-bit geometry constants keep all position sums free of wrap.
   localparam logic [10:0] X0_W       = 11'(X0);
   localparam logic [10:0] Y0_W       = 11'(Y0);
   localparam logic [10:0] DX_W       = 11'(DX);
   localparam logic [10:0] DY_W       = 11'(DY);
   localparam logic [10:0] SPR_W_W    = 11'(SPRITE_W);
   localparam logic [10:0] SPR_H_W    = 11'(SPRITE_H);
   localparam logic [10:0] STEP_X_W   = 11'(STEP_X);
   localparam logic [10:0] STEP_Y_W   = 11'(STEP_Y);
   localparam logic [10:0] X_MAX_W    = 11'(X_MAX);
   localparam logic [10:0] LEFT_LIM_W = 11'(X_MIN + STEP_X);
   localparam logic [10:0] Y_LIMIT_W  = 11'(Y_LIMIT);
   localparam logic [7:0]  BASE_W     = 8'(BASE_FRAMES);
   localparam logic [7:0]  MIN_W      = 8'(MIN_FRAMES);
   localparam logic [7:0]  N_W        = 8'(N);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_CLEARED = 2'd1,
      S_INVADED = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [10:0]     ox_q, ox_d;
   logic [10:0]     oy_q, oy_d;
   logic            dir_q, dir_d;
   logic [N-1:0]    mask_q, mask_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [FW-1:0]   frame_q, frame_d;
   logic            kill_q, kill_d;

   // Formation extents from the registered mask
   logic [COLS-1:0] col_any;
   logic [ROWS-1:0] row_any;
   logic [10:0]     lc, rc, br;
   logic [10:0]     right_edge, left_edge, bottom_after_down;

   // Hit decode and frame pacing
   logic [N-1:0]    hit_sel;
   logic            live_hit;
   logic            last_kill;
   logic [7:0]      killed;
   logic [7:0]      period;
   logic [7:0]      frame_plus;
   logic            step_due;
   logic            step_down;

   // -------------------------------------------------------------------------
   // Combinational helpers: extents, hit decode, period
   // -------------------------------------------------------------------------
   always_comb begin
      col_any = '0;
      row_any = '0;
      hit_sel = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (mask_q[r*COLS + c]) begin
               col_any[c] = 1'b1;
               row_any[r] = 1'b1;
            end
            // Out-of-range coordinates match no position, so they are dropped.
            hit_sel[r*COLS + c] = hit_valid && (32'(hit_row) == r) && (32'(hit_col) == c);
         end
      end

      // Leftmost: scan downward so the lowest set index wins.
      lc = '0;
      for (int c = COLS - 1; c >= 0; c--) begin
         if (col_any[c]) lc = 11'(c);
      end
      rc = '0;
      for (int c = 0; c < COLS; c++) begin
         if (col_any[c]) rc = 11'(c);
      end
      br = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (row_any[r]) br = 11'(r);
      end

      right_edge        = ox_q + rc * DX_W + SPR_W_W;
      left_edge         = ox_q + lc * DX_W;
      bottom_after_down = oy_q + STEP_Y_W + br * DY_W + SPR_H_W;

      live_hit  = (state_q == S_RUN) && |(hit_sel & mask_q);
      last_kill = live_hit && (cnt_q == 6'd1);

      killed     = N_W - 8'(cnt_q);
      period     = (killed + MIN_W >= BASE_W) ? MIN_W : (BASE_W - killed);
      frame_plus = 8'(frame_q) + 8'd1;
      step_due   = frame_plus >= period;
   end

   // -------------------------------------------------------------------------
   // State and datapath register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_RUN;
         ox_q    <= X0_W;
         oy_q    <= Y0_W;
         dir_q   <= 1'b1;
         mask_q  <= '1;
         cnt_q   <= 6'(N);
         frame_q <= '0;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         dir_q   <= dir_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         kill_q  <= kill_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      ox_d      = ox_q;
      oy_d      = oy_q;
      dir_d     = dir_q;
      mask_d    = mask_q;
      cnt_d     = cnt_q;
      frame_d   = frame_q;
      kill_d    = 1'b0;
      step_down = 1'b0;

      case (state_q)
         S_RUN: begin
            if (live_hit) begin
               mask_d = mask_q & ~hit_sel;
               cnt_d  = cnt_q - 6'd1;
               kill_d = 1'b1;
            end

            // The final kill wins over any step due in the same cycle,
            // including an invading step-down: the grid freezes in place.
            if (last_kill) begin
               state_d = S_CLEARED;
            end else if (frame_tick) begin
               if (step_due) begin
                  frame_d = '0;
                  // Edges come from the pre-hit mask so a same-cycle kill
                  // cannot change the step already decided for this frame.
                  if (dir_q) begin
                     if (right_edge + STEP_X_W <= X_MAX_W) begin
                        ox_d = ox_q + STEP_X_W;
                     end else begin
                        oy_d      = oy_q + STEP_Y_W;
                        dir_d     = 1'b0;
                        step_down = 1'b1;
                     end
                  end else begin
                     if (left_edge >= LEFT_LIM_W) begin
                        ox_d = ox_q - STEP_X_W;
                     end else begin
                        oy_d      = oy_q + STEP_Y_W;
                        dir_d     = 1'b1;
                        step_down = 1'b1;
                     end
                  end
                  if (step_down && (bottom_after_down >= Y_LIMIT_W)) begin
                     state_d = S_INVADED;
                  end
               end else begin
                  frame_d = frame_q + 1'b1;
               end
            end
         end

         S_CLEARED, S_INVADED: begin
            if (new_wave) begin
               state_d = S_RUN;
               ox_d    = X0_W;
               oy_d    = Y0_W;
               dir_d   = 1'b1;
               mask_d  = '1;
               cnt_d   = 6'(N);
               frame_d = '0;
            end
         end

         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      origin_x    = ox_q[9:0];
      origin_y    = oy_q[9:0];
      alive_mask  = mask_q;
      alive_count = cnt_q;
      dir_right   = dir_q;
      kill_pulse  = kill_q;
      cleared     = (state_q == S_CLEARED);
      invaded     = (state_q == S_INVADED);
      fsm_state   = state_q;
   end

endmodule

// File: tb/tb_invader_formation_ctrl.sv
module tb_invader_formation_ctrl;

  localparam int COLS = 8;
  localparam int ROWS = 3;
  localparam int N    = COLS * ROWS;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic           frame_tick = 1'b0;
  logic           hit_valid  = 1'b0;
  logic [2:0]     hit_col    = '0;
  logic [1:0]     hit_row    = '0;
  logic           new_wave   = 1'b0;
  logic [9:0]     origin_x, origin_y;
  logic [N-1:0]   alive_mask;
  logic [5:0]     alive_count;
  logic           dir_right, kill_pulse, cleared, invaded;
  logic [1:0]     fsm_state;

  invader_formation_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .hit_valid   (hit_valid),
    .hit_col     (hit_col),
    .hit_row     (hit_row),
    .new_wave    (new_wave),
    .origin_x    (origin_x),
    .origin_y    (origin_y),
    .alive_mask  (alive_mask),
    .alive_count (alive_count),
    .dir_right   (dir_right),
    .kill_pulse  (kill_pulse),
    .cleared     (cleared),
    .invaded     (invaded),
    .fsm_state   (fsm_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard: alive_count expected alongside each kill pulse
  logic [5:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model (game rules on plain ints) -------------
  int m_x, m_y, m_dir, m_frame, m_state, m_kill;  // m_state: 0 run, 1 cleared, 2 invaded
  bit m_alive[ROWS][COLS];

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        n += m_alive[r][c];
    return n;
  endfunction

  function automatic logic [N-1:0] m_mask();
    logic [N-1:0] v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[r*COLS+c] = m_alive[r][c];
    return v;
  endfunction

  task automatic model_reset();
    m_x = 40; m_y = 40; m_dir = 1; m_frame = 0; m_state = 0; m_kill = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m_alive[r][c] = 1'b1;
    exp_q.delete();
  endtask

  task automatic model_step(input bit ft, input bit hv, input int hc, input int hr, input bit nw);
    int cnt, lc, rc, br, period;
    bit live, down;
    cnt = m_count();
    lc = COLS; rc = -1; br = -1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m_alive[r][c]) begin
          if (c < lc) lc = c;
          if (c > rc) rc = c;
          if (r > br) br = r;
        end
    m_kill = 0;
    down = 0;
    if (m_state == 0) begin
      live = hv && hc < COLS && hr < ROWS && m_alive[hr][hc];
      if (live) begin
        m_alive[hr][hc] = 1'b0;
        m_kill = 1;
        exp_q.push_back(6'(cnt - 1));
      end
      if (live && cnt == 1) m_state = 1;
      else if (ft) begin
        period = 30 - (N - cnt);
        if (period < 2) period = 2;
        if (m_frame + 1 >= period) begin
          m_frame = 0;
          if (m_dir == 1) begin
            if (m_x + rc*64 + 32 + 4 <= 639) m_x += 4;
            else begin m_y += 10; m_dir = 0; down = 1; end
          end else begin
            if (m_x + lc*64 >= 0 + 4) m_x -= 4;
            else begin m_y += 10; m_dir = 1; down = 1; end
          end
          if (down && m_y + br*40 + 24 >= 440) m_state = 2;
        end else m_frame++;
      end
    end else if (nw) begin
      model_reset();
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ox"},    32'(origin_x),    32'(m_x));
    check({tag, ".oy"},    32'(origin_y),    32'(m_y));
    check({tag, ".mask"},  32'(alive_mask),  32'(m_mask()));
    check({tag, ".count"}, 32'(alive_count), 32'(m_count()));
    check({tag, ".dir"},   32'(dir_right),   32'(m_dir));
    check({tag, ".kill"},  32'(kill_pulse),  32'(m_kill));
    check({tag, ".clr"},   32'(cleared),     32'(m_state == 1));
    check({tag, ".inv"},   32'(invaded),     32'(m_state == 2));
    if (kill_pulse) begin
      if (exp_q.size() > 0) check({tag, ".kill_cnt"}, 32'(alive_count), 32'(exp_q.pop_front()));
      else check({tag, ".kill_spurious"}, 32'(kill_pulse), 32'd0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit ft, input bit hv, input int hc, input int hr, input bit nw);
    @(negedge clk);
    frame_tick = ft;
    hit_valid  = hv;
    hit_col    = 3'(hc);
    hit_row    = 2'(hr);
    new_wave   = nw;
    @(posedge clk);
    model_step(ft, hv, hc, hr, nw);
    #2;
    frame_tick = 1'b0;
    hit_valid  = 1'b0;
    new_wave   = 1'b0;
    check_all("cyc");
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0);
  endtask

  task automatic kill(input int c, input int r);
    cycle(0, 1, c, r, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    model_reset();
    #12 reset = 1'b0;
    check_all("reset");
    check("reset.ox", 32'(origin_x), 32'd40);
    check("reset.count", 32'(alive_count), 32'd24);

    // first step lands on the 30th tick
    ticks(29);
    check("t29.ox", 32'(origin_x), 32'd40);
    ticks(1);
    check("t30.ox", 32'(origin_x), 32'd44);
    check("t30.oy", 32'(origin_y), 32'd40);

    // 29 right steps then a step-down
    ticks(28 * 30);
    check("edge.ox", 32'(origin_x), 32'd156);
    ticks(30);
    check("edge.oy", 32'(origin_y), 32'd50);
    check("edge.dir", 32'(dir_right), 32'd0);
    check("edge.ox_hold", 32'(origin_x), 32'd156);

    // single hit and its repeat
    kill(3, 1);
    check("hit31.bit11", 32'(alive_mask[11]), 32'd0);
    check("hit31.count", 32'(alive_count), 32'd23);
    check("hit31.pulse", 32'(kill_pulse), 32'd1);
    kill(3, 1);
    check("rehit.pulse", 32'(kill_pulse), 32'd0);
    check("rehit.count", 32'(alive_count), 32'd23);
    cycle(0, 1, 2, 3, 0);   // row out of range
    cycle(1, 0, 0, 0, 1);   // new_wave ignored in RUN

    // 10 kills -> period 20
    do_reset();
    for (int c = 0; c < 8; c++) kill(c, 0);
    kill(0, 1); kill(1, 1);
    ticks(19);
    check("p20.before", 32'(origin_x), 32'd40);
    ticks(1);
    check("p20.step", 32'(origin_x), 32'd44);

    // only column 0 alive: travel to 604 before the step-down
    do_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 1; c < COLS; c++) kill(c, r);
    budget = 0;
    while (dir_right && budget < 3000) begin ticks(1); budget++; end
    check("col0.timeout", 32'(budget < 3000), 32'd1);
    check("col0.ox", 32'(origin_x), 32'd604);
    check("col0.oy", 32'(origin_y), 32'd50);

    // invasion with corners of row 2 left alive
    do_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!(r == 2 && (c == 0 || c == 7))) kill(c, r);
    budget = 0;
    while (!invaded && budget < 12000) begin ticks(1); budget++; end
    check("inv.timeout", 32'(budget < 12000), 32'd1);
    check("inv.oy", 32'(origin_y), 32'd340);
    ticks(40);
    kill(0, 2);
    check("inv.nokill", 32'(kill_pulse), 32'd0);
    cycle(0, 0, 0, 0, 1);
    check("nw.ox", 32'(origin_x), 32'd40);
    check("nw.mask", 32'(alive_mask), 32'hFF_FFFF);
    check("nw.state", 32'(fsm_state), 32'd0);

    // last kill on a due frame_tick: cleared, no step
    do_reset();
    for (int i = 0; i < 23; i++) kill(i % COLS, i / COLS);
    ticks(6);
    cycle(1, 1, 7, 2, 0);
    check("clr.flag", 32'(cleared), 32'd1);
    check("clr.ox", 32'(origin_x), 32'd40);
    ticks(20);
    check("clr.hold", 32'(origin_x), 32'd40);
    cycle(0, 0, 0, 0, 1);

    // randomized play
    for (int i = 0; i < 5000; i++) begin
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 30) == 0);
    end

    // async reset mid-run
    ticks(7);
    kill(4, 0);
    do_reset();
    ticks(3);

    check("kill_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
